// File: rtl/mesh_vlink_row.sv
// Vertical link stage between two adjacent mesh rows.
// Each column carries an independent south-to-north and north-to-south
// elastic FIFO, plus per-column enable, flush and sticky protocol-error flags.

module mesh_vlink_fifo #(
    parameter int PACKET_WIDTH = 64,
    parameter int DEPTH        = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    flush_i,
    input  logic                    err_clr_i,
    input  logic                    si_i,
    input  logic [PACKET_WIDTH-1:0] di_i,
    output logic                    ri_o,
    output logic                    so_o,
    output logic [PACKET_WIDTH-1:0] data_o,
    input  logic                    ro_i,
    output logic                    err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PACKET_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    push, pop;

    // Handshake outputs come from registered state only (no ro->ri path).
    always_comb begin
        ri_o   = en_i & (cnt_q < CW'(DEPTH)) & rst_n;
        so_o   = en_i & (cnt_q != '0);
        data_o = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
        push   = si_i & ri_o;
        pop    = so_o & ro_i;
    end

    // Next-state for pointers, occupancy and error flag; flush overrides push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            cnt_d    = cnt_q + CW'(push) - CW'(pop);
        end
        err_d = err_clr_i ? 1'b0 : (err_q | (si_i & ~ri_o & en_i));
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Packet storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= di_i;
        end
    end

    assign err_o = err_q;

endmodule

module mesh_vlink_row #(
    parameter int NUM_COLS     = 4,
    parameter int PACKET_WIDTH = 64,
    parameter int DEPTH        = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_COLS-1:0]              snsi,
    input  logic [NUM_COLS*PACKET_WIDTH-1:0] sndi,
    output logic [NUM_COLS-1:0]              snri,
    output logic [NUM_COLS-1:0]              snso,
    output logic [NUM_COLS*PACKET_WIDTH-1:0] sndo,
    input  logic [NUM_COLS-1:0]              snro,
    input  logic [NUM_COLS-1:0]              nssi,
    input  logic [NUM_COLS*PACKET_WIDTH-1:0] nsdi,
    output logic [NUM_COLS-1:0]              nsri,
    output logic [NUM_COLS-1:0]              nsso,
    output logic [NUM_COLS*PACKET_WIDTH-1:0] nsdo,
    input  logic [NUM_COLS-1:0]              nsro,
    input  logic [NUM_COLS-1:0]              link_en,
    input  logic [NUM_COLS-1:0]              flush,
    input  logic                             err_clr,
    output logic [NUM_COLS-1:0]              err_sn,
    output logic [NUM_COLS-1:0]              err_ns
);

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        mesh_vlink_fifo #(
            .PACKET_WIDTH (PACKET_WIDTH),
            .DEPTH        (DEPTH)
        ) u_sn (
            .clk       (clk),
            .rst_n     (reset),
            .en_i      (link_en[c]),
            .flush_i   (flush[c]),
            .err_clr_i (err_clr),
            .si_i      (snsi[c]),
            .di_i      (sndi[c*PACKET_WIDTH +: PACKET_WIDTH]),
            .ri_o      (snri[c]),
            .so_o      (snso[c]),
            .data_o    (sndo[c*PACKET_WIDTH +: PACKET_WIDTH]),
            .ro_i      (snro[c]),
            .err_o     (err_sn[c])
        );

        mesh_vlink_fifo #(
            .PACKET_WIDTH (PACKET_WIDTH),
            .DEPTH        (DEPTH)
        ) u_ns (
            .clk       (clk),
            .rst_n     (reset),
            .en_i      (link_en[c]),
            .flush_i   (flush[c]),
            .err_clr_i (err_clr),
            .si_i      (nssi[c]),
            .di_i      (nsdi[c*PACKET_WIDTH +: PACKET_WIDTH]),
            .ri_o      (nsri[c]),
            .so_o      (nsso[c]),
            .data_o    (nsdo[c*PACKET_WIDTH +: PACKET_WIDTH]),
            .ro_i      (nsro[c]),
            .err_o     (err_ns[c])
        );
    end

endmodule

// File: doc/mesh_vlink_row.md
Name: mesh_vlink_row

Overview:
- Parametrised vertical link stage inserted between two adjacent mesh rows.
- Carries NUM_COLS independent column links, each with a south-to-north (sn) channel and a north-to-south (ns) channel.
- Every channel is an elastic FIFO of DEPTH packets using the router send/ready/data handshake.
- Breaks the long inter-row timing path and adds per-column enable, flush and protocol-violation flags, which fixed 4-column rows lack.

Parameters:
- NUM_COLS, 4: number of columns (routers per row), 1..16.
- PACKET_WIDTH, 64: packet width in bits.
- DEPTH, 2: entries per channel FIFO; power of two, 2..16.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- snsi  in  NUM_COLS  lower-row router north-going send, one bit per column.
- sndi  in  NUM_COLS*PACKET_WIDTH  north-going data; column c occupies bits [c*PACKET_WIDTH +: PACKET_WIDTH].
- snri  out  NUM_COLS  link ready to accept north-going packet.
- snso  out  NUM_COLS  send to upper-row router.
- sndo  out  NUM_COLS*PACKET_WIDTH  data to upper-row router.
- snro  in  NUM_COLS  upper-row router ready.
- nssi  in  NUM_COLS  upper-row router south-going send.
- nsdi  in  NUM_COLS*PACKET_WIDTH  south-going data.
- nsri  out  NUM_COLS  link ready to accept south-going packet.
- nsso  out  NUM_COLS  send to lower-row router.
- nsdo  out  NUM_COLS*PACKET_WIDTH  data to lower-row router.
- nsro  in  NUM_COLS  lower-row router ready.
- link_en  in  NUM_COLS  per-column link enable.
- flush  in  NUM_COLS  per-column synchronous flush of both channels.
- err_clr  in  1  clears all error flags.
- err_sn  out  NUM_COLS  sticky flag: sn send presented while sn not ready.
- err_ns  out  NUM_COLS  sticky flag: ns send presented while ns not ready.

Behaviour:
- 2*NUM_COLS identical, independent channels. Each channel has a DEPTH-entry memory, write pointer, read pointer and count (0..DEPTH).
- Reset (reset=0, asynchronous), all channels:
  - count, pointers and error flags go to 0.
  - *so=0, *do=0.
  - *ri forced 0 while reset is low.
  - Memory contents are not reset.
- Ready and send:
  - ri = link_en[c] & (count<DEPTH) & reset. ri is derived from registered state only; there is no combinational ro->ri path.
  - so = link_en[c] & (count>0).
  - do = head entry when count>0, else 0.
- Push occurs when si & ri. Pop occurs when so & ro. Both in one cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: a packet pushed at edge t appears on so/do after edge t, i.e. one cycle minimum. Throughput is 1 packet/cycle/channel when the downstream router holds ro=1.
- Full (count=DEPTH): ri=0, and no push even if a pop occurs that cycle. Ready becomes 1 the cycle after the pop.
- Empty: so=0, do=0; a push and a pop cannot coincide.
- Data stability: while so=1 & ro=0, do and so hold stable.
- Ordering: FIFO; no reordering within a channel; no interaction between channels.
- link_en[c]=0:
  - Both channels of column c drive ri=0 and so=0.
  - Contents and count are retained and resume on re-enable.
  - No push or pop occurs.
- flush[c]=1 (sampled at edge):
  - Both channels of column c: count and pointers go to 0. Flush takes priority over any same-cycle push/pop.
  - The packet on do at a flush edge is treated as not delivered, even if ro=1 that cycle.
  - Error flags are not affected.
- Error flags:
  - err_sn[c] is set at an edge where snsi[c]=1 & snri[c]=0 & link_en[c]=1.
  - err_ns[c] uses the same rule on nssi/nsri.
  - Flags are sticky.
  - err_clr=1 clears all flags; clear wins over a same-cycle set.
- Reset asserted mid-transfer: all in-flight packets are discarded; no partial output.

Test Plan:
- Reset then idle, NUM_COLS=4, DEPTH=2, link_en=4'hF -> snso=nsso=0, sndo=nsdo=0, snri=nsri=4'hF one cycle after reset release, err_*=0.
- Column 1 sn: push 64'hA5A5_0000_0000_0001 at cycle 0 with snro[1]=1 -> snso[1]=1 with sndo[127:64]=that value at cycle 1; popped at cycle 1; snso[1]=0 at cycle 2.
- Column 2 ns, nsro[2]=0: push 3 packets P0,P1,P2 back to back -> nsri[2] drops after second push; P2 not accepted and err_ns[2]=1. Raise nsro -> P0 then P1 delivered in order on consecutive cycles, then nsri[2]=1.
- Full-rate streaming on all 8 channels, 100 random packets each, ready always 1 -> every packet delivered in order, 1 per cycle, no error flags.
- Column 0 holding 2 sn packets: link_en[0]=0 for 5 cycles (snso[0]=0, snri[0]=0, others unaffected), re-enable -> both delivered. Then fill again and pulse flush[0] -> count 0, snso[0]=0 next cycle.
- err_ns[3] set; pulse err_clr in the same cycle as a new violation -> flag reads 0. Assert reset mid-stream -> all so=0 and do=0 immediately (asynchronous).
